// File: rtl/maze_level_renderer_if.sv
// maze_level_renderer_if: level-load request handshake and level ROM bus
interface maze_level_renderer_if #(
    parameter int COORD_W = 10,
    parameter int ADDR_W = 6,
    parameter int LVL_W = 2
);
    logic [LVL_W-1:0] level_sel;
    logic level_req;
    logic load_busy;
    logic [ADDR_W-1:0] rom_addr;
    logic [4*COORD_W:0] rom_data;
    modport master(output level_sel, level_req, rom_data, input load_busy, rom_addr);
    modport slave(input level_sel, level_req, rom_data, output load_busy, rom_addr);
endinterface

// File: rtl/maze_level_renderer.sv
// maze_level_renderer: ROM-loaded wall/goal rectangle renderer with cursor collision flags
module maze_level_renderer #(
    parameter int NUM_BARS = 12,
    parameter int NUM_LEVELS = 4,
    parameter int COORD_W = 10,
    parameter int ADDR_W = 6,
    parameter logic [2:0] WALL_RGB = 3'b011,
    parameter logic [2:0] GOAL_RGB = 3'b001
) (
    input  logic clk,
    input  logic reset,
    maze_level_renderer_if.slave lvl,
    input  logic video_on,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic frame_start,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    output logic [2:0] graph_rgb,
    output logic graph_on,
    output logic finalbox,
    output logic hit_wall,
    output logic hit_goal
);
    localparam int LVL_W = NUM_LEVELS > 1 ? $clog2(NUM_LEVELS) : 1;
    localparam int CNT_W = $clog2(NUM_BARS + 1);
    typedef enum logic {IDLE, LOAD} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] idx, wr_idx;
    logic [LVL_W-1:0] sel_c;
    logic [ADDR_W-1:0] start_addr;
    logic start, busy, clr, same_q, set_ok;
    logic [NUM_BARS-1:0] t_goal, hit, hit_q, goal_q;
    logic [COORD_W-1:0] t_xl [NUM_BARS];
    logic [COORD_W-1:0] t_xr [NUM_BARS];
    logic [COORD_W-1:0] t_yt [NUM_BARS];
    logic [COORD_W-1:0] t_yb [NUM_BARS];
    logic von_q, busy_q, on_q, fin_q;
    logic [COORD_W-1:0] px_q, py_q, plx_q, ply_q;
    logic [2:0] rgb_q;

    assign busy = state == LOAD;
    assign start = state == IDLE && lvl.level_req;
    assign sel_c = lvl.level_sel > LVL_W'(NUM_LEVELS - 1) ? LVL_W'(NUM_LEVELS - 1) : lvl.level_sel;
    assign start_addr = ADDR_W'(int'(sel_c) * NUM_BARS);
    assign wr_idx = idx - 1'b1;
    assign lvl.load_busy = busy;

    always_comb begin
        state_nx = start ? LOAD : (busy && idx == CNT_W'(NUM_BARS)) ? IDLE : state;
    end

    // rom_addr holds on the last address while the final entry is written
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            idx <= '0;
            lvl.rom_addr <= '0;
        end else begin
            state <= state_nx;
            idx <= busy ? idx + 1'b1 : '0;
            if (start)
                lvl.rom_addr <= start_addr;
            else if (busy && idx < CNT_W'(NUM_BARS - 1))
                lvl.rom_addr <= lvl.rom_addr + 1'b1;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            t_goal <= '0;
            for (int b = 0; b < NUM_BARS; b++) begin
                t_xl[b] <= '1;
                t_xr[b] <= '0;
                t_yt[b] <= '0;
                t_yb[b] <= '0;
            end
        end else if (busy && idx != '0) begin
            {t_goal[wr_idx], t_xl[wr_idx], t_xr[wr_idx], t_yt[wr_idx], t_yb[wr_idx]} <= lvl.rom_data;
        end

    // a disabled entry (xl > xr or yt > yb) can never satisfy both range tests
    for (genvar b = 0; b < NUM_BARS; b++) begin : g_slot
        assign hit[b] = t_xl[b] <= pix_x && pix_x <= t_xr[b] && t_yt[b] <= pix_y && pix_y <= t_yb[b];
    end

    assign same_q = px_q == plx_q && py_q == ply_q;
    assign set_ok = !busy_q && !busy && same_q;
    assign clr = frame_start || start;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            hit_q <= '0;
            goal_q <= '0;
            von_q <= 1'b0;
            busy_q <= 1'b0;
            px_q <= '0;
            py_q <= '0;
            plx_q <= '0;
            ply_q <= '0;
            rgb_q <= 3'b000;
            on_q <= 1'b0;
            fin_q <= 1'b0;
            hit_wall <= 1'b0;
            hit_goal <= 1'b0;
        end else begin
            hit_q <= hit;
            goal_q <= hit & t_goal;
            von_q <= video_on;
            busy_q <= busy;
            px_q <= pix_x;
            py_q <= pix_y;
            plx_q <= player_x;
            ply_q <= player_y;
            rgb_q <= (busy_q || !von_q) ? 3'b000 : |goal_q ? GOAL_RGB : |hit_q ? WALL_RGB : 3'b000;
            on_q <= !busy_q && |hit_q;
            fin_q <= !busy_q && |goal_q;
            hit_wall <= (set_ok && |(hit_q & ~goal_q)) || (hit_wall && !clr);
            hit_goal <= (set_ok && |goal_q) || (hit_goal && !clr);
        end

    assign graph_rgb = busy ? 3'b000 : rgb_q;
    assign graph_on = on_q && !busy;
    assign finalbox = fin_q && !busy;
endmodule

// File: doc/maze_level_renderer.md
# maze_level_renderer

Parametrised maze-level graphics generator for the VGA pixel path: draws up to NUM_BARS rectangular walls and one or more goal boxes per level, with level geometry loaded at run time from an external level ROM instead of fixed constants. Sits between the VGA sync/pixel counter and the RGB multiplexer. It also provides per-frame collision flags for the player cursor, so one instance serves every level of the game.

## Interface
- NUM_BARS, 12: rectangle slots per level.
- NUM_LEVELS, 4: levels stored in the ROM.
- COORD_W, 10: pixel coordinate width.
- ADDR_W, 6: ROM address width; must satisfy 2^ADDR_W ≥ NUM_LEVELS*NUM_BARS.
- WALL_RGB, 3'b011: wall colour.
- GOAL_RGB, 3'b001: goal colour.
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- level_sel  in  clog2(NUM_LEVELS)  level to load; sampled on the level_req cycle.
- level_req  in  1  one-cycle load request.
- load_busy  out  1  high while the slot table is being loaded.
- rom_addr  out  ADDR_W  level ROM address.
- rom_data  in  4*COORD_W+1  {goal, xl, xr, yt, yb}; valid one cycle after rom_addr.
- video_on  in  1  visible-area flag.
- pix_x, pix_y  in  COORD_W each  current pixel.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- player_x, player_y  in  COORD_W each  cursor position.
- graph_rgb  out  3  pixel colour.
- graph_on  out  1  pixel lies in any enabled slot.
- finalbox  out  1  pixel lies in a goal slot.
- hit_wall, hit_goal  out  1 each  sticky collision flags.

## Operation
- Slot table: NUM_BARS entries {goal, xl, xr, yt, yb}. An entry is enabled when xl ≤ xr and yt ≤ yb. A pixel is inside an entry when xl ≤ pix_x ≤ xr and yt ≤ pix_y ≤ yb (inclusive on all four edges).
- FSM has two states, IDLE and LOAD.
  - IDLE → LOAD on level_req. The cycle of transition latches base = level_sel*NUM_BARS and sets i = 0.
  - In LOAD, rom_addr = base + i and i increments every cycle. rom_data arriving one cycle later is written to entry i−1.
  - LOAD → IDLE after entry NUM_BARS−1 is written.
  - load_busy is high for exactly NUM_BARS+1 cycles.
  - level_req while busy is ignored.
  - level_sel ≥ NUM_LEVELS is clamped to NUM_LEVELS−1.
- While load_busy is high, graph_on, finalbox and graph_rgb are forced to 0, and hit flag setting is suppressed.
- Colour priority: when the delayed video_on is 0, the colour is 000. Otherwise it is GOAL_RGB if any goal slot hits, else WALL_RGB if any slot hits, else 000.
- Collision:
  - When the pipelined pixel equals (player_x, player_y) and the pixel is in a wall slot (goal=0), hit_wall is set.
  - When the pipelined pixel equals (player_x, player_y) and the pixel is in a goal slot, hit_goal is set.
  - player_x/player_y are delayed with the pixel pipeline before comparison.
  - Both flags clear on frame_start and on entry to LOAD.
  - If a set and a frame_start clear occur in the same cycle, set wins.
- Reset, asynchronous and active-low:
  - FSM goes to IDLE; i and rom_addr go to 0.
  - All entries become disabled: xl = all ones, xr = 0, goal = 0.
  - All outputs and pipeline registers go to 0.
  - Reset during LOAD abandons the load; the table is left fully disabled.

## Timing
- Pixel path latency is 2 cycles.
  - Stage 1 registers the per-slot hit vectors plus the delayed video_on, pix and player inputs.
  - Stage 2 registers graph_rgb, graph_on and finalbox.
- A pixel presented at cycle t appears on the outputs at cycle t+2.
- hit flags update at t+2 for a pixel presented at t.
- A table write at cycle c affects pixels presented from cycle c+1.
- rom_addr is registered; rom_data is sampled exactly one cycle after its address.
- The first valid pixel after load completes is the one presented on the cycle load_busy falls.

## Test plan
- Reset mid-operation → all outputs 0, load_busy 0, and a full-screen sweep yields graph_on = 0 everywhere.
- Load level 0 with slot 0 = {0, 300, 580, 80, 120} and slot 11 = {1, 140, 180, 400, 440}; check load_busy lasts 13 cycles; pixel (300,80) → rgb 011 two cycles later; (581,80) → 000; (160,420) → rgb 001 with finalbox = 1.
- Overlapping wall and goal at (150,410) → GOAL_RGB wins; video_on = 0 at (300,80) → 000 with graph_on still 1.
- Player at (310,100) inside a wall → hit_wall set when the raster reaches it; frame_start alone clears it; frame_start coincident with a set → flag remains 1.
- level_req for level 2 issued during an ongoing load of level 1 → ignored, and rom_addr sequence is 12..23 only; level_sel = 7 → clamped, addresses 36..47.
- Entry with xl = 400, xr = 399 → never drawn; reset asserted at load cycle 5 → table disabled, FSM IDLE.
